// File: rtl/ysyx_axi4_pkg.sv
// Shared AXI4 encodings, FSM states and response helpers for the ysyx AXI4 peripherals.
package ysyx_axi4_pkg;

    localparam logic [1:0] BurstFixed    = 2'b00;
    localparam logic [1:0] BurstIncr     = 2'b01;
    localparam logic [1:0] BurstWrap     = 2'b10;
    localparam logic [1:0] BurstReserved = 2'b11;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExokay = 2'b01;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRdata,
        StWdata,
        StBresp
    } axi_state_e;

    // Worst of two responses; EXOKAY ranks with OKAY.
    function automatic logic [1:0] resp_max(logic [1:0] a, logic [1:0] b);
        logic [1:0] ra;
        logic [1:0] rb;
        ra = (a == RespExokay) ? RespOkay : a;
        rb = (b == RespExokay) ? RespOkay : b;
        return (ra > rb) ? ra : rb;
    endfunction

endpackage

// File: rtl/ysyx_axi4_addr_gen.sv
// Combinational AXI4 beat address step and decode-window check.
module ysyx_axi4_addr_gen
    import ysyx_axi4_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0f00_0000
) (
    input  logic [XLEN-1:0] addr,
    input  logic [2:0]      size,
    input  logic [1:0]      burst,
    output logic [XLEN-1:0] next_addr,
    output logic            in_range
);

    localparam logic [XLEN-1:0] Span = XLEN'(DEPTH * 4);

    logic [XLEN-1:0] offset;

    always_comb begin
        offset   = addr - BASE_ADDR;
        in_range = offset < Span;
        if (burst == BurstIncr) begin
            next_addr = addr + (XLEN'(1) << size);
        end else begin
            next_addr = addr;
        end
    end

endmodule

// File: rtl/ysyx_axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed SRAM: one outstanding burst, FIXED/INCR,
// strobed writes, round-robin arbitration between AR and AW.
module ysyx_axi4_slave_mem
    import ysyx_axi4_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0f00_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [XLEN-1:0]   io_slave_araddr,
    input  logic [3:0]        io_slave_arid,
    input  logic [7:0]        io_slave_arlen,
    input  logic [2:0]        io_slave_arsize,
    input  logic [1:0]        io_slave_arburst,
    input  logic              io_slave_arvalid,
    output logic              io_slave_arready,
    output logic [XLEN-1:0]   io_slave_rdata,
    output logic [3:0]        io_slave_rid,
    output logic [1:0]        io_slave_rresp,
    output logic              io_slave_rlast,
    output logic              io_slave_rvalid,
    input  logic              io_slave_rready,
    input  logic [XLEN-1:0]   io_slave_awaddr,
    input  logic [3:0]        io_slave_awid,
    input  logic [7:0]        io_slave_awlen,
    input  logic [2:0]        io_slave_awsize,
    input  logic [1:0]        io_slave_awburst,
    input  logic              io_slave_awvalid,
    output logic              io_slave_awready,
    input  logic [XLEN-1:0]   io_slave_wdata,
    input  logic [XLEN/8-1:0] io_slave_wstrb,
    input  logic              io_slave_wlast,
    input  logic              io_slave_wvalid,
    output logic              io_slave_wready,
    output logic [3:0]        io_slave_bid,
    output logic [1:0]        io_slave_bresp,
    output logic              io_slave_bvalid,
    input  logic              io_slave_bready
);

    localparam int unsigned IdxW  = $clog2(DEPTH);
    localparam int unsigned StrbW = XLEN / 8;

    axi_state_e      state_q, state_d;
    logic            last_write_q;
    logic [7:0]      beat_q, len_q;
    logic [XLEN-1:0] addr_q;
    logic [3:0]      id_q;
    logic [2:0]      size_q;
    logic [1:0]      burst_q;
    logic [XLEN-1:0] rdata_q;
    logic [1:0]      rresp_q, bresp_q;

    logic [XLEN-1:0] mem [DEPTH];

    logic            ar_fire, aw_fire, r_fire, w_fire, last_beat;
    logic [XLEN-1:0] gen_addr, gen_next;
    logic [2:0]      gen_size;
    logic [1:0]      gen_burst, gen_resp, w_beat_resp;
    logic            gen_in_range, cfg_err;
    logic [IdxW-1:0] word_idx;
    logic [XLEN-1:0] ld_data;

    assign ar_fire   = io_slave_arvalid && io_slave_arready;
    assign aw_fire   = io_slave_awvalid && io_slave_awready;
    assign r_fire    = io_slave_rvalid && io_slave_rready;
    assign w_fire    = io_slave_wvalid && io_slave_wready;
    assign last_beat = beat_q == len_q;

    // In IDLE the generator looks at the incoming AR; afterwards addr_q is the beat to
    // load next on reads and the beat being written on writes.
    assign gen_addr  = (state_q == StIdle) ? io_slave_araddr  : addr_q;
    assign gen_size  = (state_q == StIdle) ? io_slave_arsize  : size_q;
    assign gen_burst = (state_q == StIdle) ? io_slave_arburst : burst_q;

    ysyx_axi4_addr_gen #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .addr      (gen_addr),
        .size      (gen_size),
        .burst     (gen_burst),
        .next_addr (gen_next),
        .in_range  (gen_in_range)
    );

    assign cfg_err  = (gen_burst == BurstWrap) || (gen_burst == BurstReserved) ||
                      (gen_size > 3'd2);
    assign word_idx = IdxW'((gen_addr - BASE_ADDR) >> 2);

    always_comb begin
        if (!gen_in_range) begin
            gen_resp = RespDecerr;
        end else if (cfg_err) begin
            gen_resp = RespSlverr;
        end else begin
            gen_resp = RespOkay;
        end
    end

    assign ld_data     = (gen_resp == RespOkay) ? mem[word_idx] : '0;
    assign w_beat_resp = resp_max(gen_resp,
                                  (io_slave_wlast != last_beat) ? RespSlverr : RespOkay);

    always_ff @(posedge clock) begin
        if (w_fire && gen_resp == RespOkay) begin
            for (int b = 0; b < StrbW; b++) begin
                if (io_slave_wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= io_slave_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ar_fire) begin
                    state_d = StRdata;
                end else if (aw_fire) begin
                    state_d = StWdata;
                end
            end
            StRdata: if (r_fire && last_beat) state_d = StIdle;
            StWdata: if (w_fire && last_beat) state_d = StBresp;
            StBresp: if (io_slave_bready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        io_slave_arready = 1'b0;
        io_slave_awready = 1'b0;
        io_slave_rvalid  = 1'b0;
        io_slave_wready  = 1'b0;
        io_slave_bvalid  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Exactly one ready when both valids are up: the side not served last wins.
                io_slave_arready = reset && (!io_slave_awvalid || last_write_q);
                io_slave_awready = reset && (!io_slave_arvalid || !last_write_q);
            end
            StRdata: io_slave_rvalid = 1'b1;
            StWdata: io_slave_wready = 1'b1;
            StBresp: io_slave_bvalid = 1'b1;
            default: ;
        endcase
    end

    assign io_slave_rlast  = (state_q == StRdata) && last_beat;
    assign io_slave_rdata  = rdata_q;
    assign io_slave_rresp  = rresp_q;
    assign io_slave_rid    = id_q;
    assign io_slave_bid    = id_q;
    assign io_slave_bresp  = bresp_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_write_q <= 1'b1;
            beat_q       <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            id_q         <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            rdata_q      <= '0;
            rresp_q      <= RespOkay;
            bresp_q      <= RespOkay;
        end else if (ar_fire) begin
            addr_q       <= gen_next;
            id_q         <= io_slave_arid;
            len_q        <= io_slave_arlen;
            size_q       <= io_slave_arsize;
            burst_q      <= io_slave_arburst;
            last_write_q <= 1'b0;
            beat_q       <= '0;
            rdata_q      <= ld_data;
            rresp_q      <= gen_resp;
        end else if (aw_fire) begin
            addr_q       <= io_slave_awaddr;
            id_q         <= io_slave_awid;
            len_q        <= io_slave_awlen;
            size_q       <= io_slave_awsize;
            burst_q      <= io_slave_awburst;
            last_write_q <= 1'b1;
            beat_q       <= '0;
            bresp_q      <= RespOkay;
        end else if (r_fire && !last_beat) begin
            addr_q  <= gen_next;
            beat_q  <= beat_q + 8'd1;
            rdata_q <= ld_data;
            rresp_q <= gen_resp;
        end else if (w_fire) begin
            addr_q  <= gen_next;
            beat_q  <= beat_q + 8'd1;
            bresp_q <= resp_max(bresp_q, w_beat_resp);
        end
    end

endmodule

// File: tb/tb_ysyx_axi4_slave_mem.sv
// Bench for ysyx_axi4_slave_mem: vector table of bursts checked through a scoreboard
// against a byte-accurate memory model, plus arbitration and mid-burst reset sequences.
module tb_ysyx_axi4_slave_mem;

    logic        clock, reset;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        ar_valid, arready;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast, rvalid, r_ready;
    logic [31:0] aw_addr;
    logic [3:0]  aw_id;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_valid, awready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last, w_valid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, b_ready;

    ysyx_axi4_slave_mem dut (
        .clock            (clock),
        .reset            (reset),
        .io_slave_araddr  (ar_addr),
        .io_slave_arid    (ar_id),
        .io_slave_arlen   (ar_len),
        .io_slave_arsize  (ar_size),
        .io_slave_arburst (ar_burst),
        .io_slave_arvalid (ar_valid),
        .io_slave_arready (arready),
        .io_slave_rdata   (rdata),
        .io_slave_rid     (rid),
        .io_slave_rresp   (rresp),
        .io_slave_rlast   (rlast),
        .io_slave_rvalid  (rvalid),
        .io_slave_rready  (r_ready),
        .io_slave_awaddr  (aw_addr),
        .io_slave_awid    (aw_id),
        .io_slave_awlen   (aw_len),
        .io_slave_awsize  (aw_size),
        .io_slave_awburst (aw_burst),
        .io_slave_awvalid (aw_valid),
        .io_slave_awready (awready),
        .io_slave_wdata   (w_data),
        .io_slave_wstrb   (w_strb),
        .io_slave_wlast   (w_last),
        .io_slave_wvalid  (w_valid),
        .io_slave_wready  (wready),
        .io_slave_bid     (bid),
        .io_slave_bresp   (bresp),
        .io_slave_bvalid  (bvalid),
        .io_slave_bready  (b_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] data;      // beat b carries data + b
        logic [3:0]  strb;
        int          early;     // beat carrying an early wlast, -1 for none
        logic [15:0] rpat;      // rready per cycle, LSB first, 1 after bit 15
        logic [1:0]  exp_bresp; // writes only
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    localparam int NumVec = 17;

    vec_t        vecs [NumVec];
    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [31:0] mdl [logic [29:0]];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] mdl_resp(logic [31:0] a, logic [2:0] s, logic [1:0] bu);
        if (a < 32'h0f00_0000 || a >= 32'h0f00_1000) return 2'b11;
        if (bu > 2'b01 || s > 3'd2) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] mdl_next(logic [31:0] a, logic [2:0] s, logic [1:0] bu);
        return (bu == 2'b01) ? a + (32'd1 << s) : a;
    endfunction

    function automatic logic [31:0] mdl_rd(logic [31:0] a);
        return mdl.exists(a[31:2]) ? mdl[a[31:2]] : 32'h0;
    endfunction

    // sel: 0 arready, 1 awready, 2 wready; handshake completes on the posedge after a hit.
    task automatic wait_hs(input int sel, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 32 && !hit; i++) begin
            @(negedge clock);
            case (sel)
                0:       hit = arready;
                1:       hit = awready;
                default: hit = wready;
            endcase
            @(posedge clock);
            #1;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: got no ready, expected one within 32 cycles", name);
        end
    endtask

    task automatic axi_write(input vec_t v);
        logic [31:0] a, wd, w;
        bexp_t       be;
        bit          hit;
        a = v.addr;
        for (int b = 0; b <= int'(v.len); b++) begin
            if (mdl_resp(a, v.size, v.burst) == 2'b00) begin
                wd = v.data + 32'(b);
                w  = mdl_rd(a);
                for (int k = 0; k < 4; k++) if (v.strb[k]) w[8*k +: 8] = wd[8*k +: 8];
                mdl[a[31:2]] = w;
            end
            a = mdl_next(a, v.size, v.burst);
        end
        bq.push_back('{id: v.id, resp: v.exp_bresp});
        aw_addr = v.addr; aw_id = v.id; aw_len = v.len; aw_size = v.size; aw_burst = v.burst;
        aw_valid = 1'b1;
        wait_hs(1, "aw handshake");
        aw_valid = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            w_data  = v.data + 32'(b);
            w_strb  = v.strb;
            w_last  = (v.early >= 0) ? (b == v.early) : (b == int'(v.len));
            w_valid = 1'b1;
            wait_hs(2, "w handshake");
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        b_ready = 1'b1;
        hit     = 1'b0;
        for (int i = 0; i < 32 && !hit; i++) begin
            @(negedge clock);
            if (bvalid) begin
                hit = 1'b1;
                be  = bq.pop_front();
                check("bid", 32'(bid), 32'(be.id));
                check("bresp", 32'(bresp), 32'(be.resp));
            end
            @(posedge clock);
            #1;
        end
        b_ready = 1'b0;
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL bvalid: got 0 for 32 cycles, expected 1");
            bq.delete();
        end
    endtask

    task automatic axi_read(input vec_t v);
        logic [31:0] a;
        rexp_t       e;
        int          cyc;
        a = v.addr;
        for (int b = 0; b <= int'(v.len); b++) begin
            e.resp = mdl_resp(a, v.size, v.burst);
            e.data = (e.resp == 2'b00) ? mdl_rd(a) : 32'h0;
            e.last = (b == int'(v.len));
            e.id   = v.id;
            rq.push_back(e);
            a = mdl_next(a, v.size, v.burst);
        end
        ar_addr = v.addr; ar_id = v.id; ar_len = v.len; ar_size = v.size; ar_burst = v.burst;
        ar_valid = 1'b1;
        wait_hs(0, "ar handshake");
        ar_valid = 1'b0;
        cyc = 0;
        while (rq.size() > 0 && cyc < 64) begin
            r_ready = (cyc < 16) ? v.rpat[cyc] : 1'b1;
            @(negedge clock);
            check("rvalid", 32'(rvalid), 32'd1);
            if (rvalid) begin
                check("rdata", rdata, rq[0].data);
                check("rresp", 32'(rresp), 32'(rq[0].resp));
                check("rlast", 32'(rlast), 32'(rq[0].last));
                check("rid", 32'(rid), 32'(rq[0].id));
                if (r_ready) void'(rq.pop_front());
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        r_ready = 1'b0;
        if (rq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL read burst: got %0d beats outstanding, expected 0", rq.size());
            rq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        ar_addr = '0; ar_id = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b0;
        aw_addr = '0; aw_id = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
        r_ready = 1'b0; b_ready = 1'b0;

        //            wr    addr            id     len    sz    burst  data            strb  early rpat      bresp
        vecs[0]  = '{1'b1, 32'h0f00_0010, 4'd5,  8'd0, 3'd2, 2'b01, 32'hdead_beef, 4'hf, -1, 16'hffff, 2'b00};
        vecs[1]  = '{1'b0, 32'h0f00_0010, 4'd6,  8'd0, 3'd2, 2'b01, 32'h0,         4'h0, -1, 16'hffff, 2'b00};
        vecs[2]  = '{1'b1, 32'h0f00_0000, 4'd1,  8'd3, 3'd2, 2'b01, 32'h1000_0000, 4'hf, -1, 16'hffff, 2'b00};
        vecs[3]  = '{1'b0, 32'h0f00_0000, 4'd2,  8'd3, 3'd2, 2'b01, 32'h0,         4'h0, -1, 16'hffed, 2'b00};
        vecs[4]  = '{1'b1, 32'h0f00_0020, 4'd3,  8'd0, 3'd2, 2'b01, 32'h1122_3344, 4'hf, -1, 16'hffff, 2'b00};
        vecs[5]  = '{1'b1, 32'h0f00_0020, 4'd4,  8'd0, 3'd2, 2'b01, 32'haaaa_bbbb, 4'h2, -1, 16'hffff, 2'b00};
        vecs[6]  = '{1'b0, 32'h0f00_0020, 4'd7,  8'd0, 3'd2, 2'b01, 32'h0,         4'h0, -1, 16'hffff, 2'b00};
        vecs[7]  = '{1'b1, 32'h8000_0000, 4'd8,  8'd0, 3'd2, 2'b01, 32'h1234_5678, 4'hf, -1, 16'hffff, 2'b11};
        vecs[8]  = '{1'b0, 32'h0f00_0000, 4'd9,  8'd1, 3'd2, 2'b10, 32'h0,         4'h0, -1, 16'hffff, 2'b00};
        vecs[9]  = '{1'b1, 32'h0f00_0040, 4'd10, 8'd3, 3'd2, 2'b01, 32'h2000_0000, 4'hf,  1, 16'hffff, 2'b10};
        vecs[10] = '{1'b0, 32'h0f00_0040, 4'd11, 8'd3, 3'd2, 2'b01, 32'h0,         4'h0, -1, 16'h5555, 2'b00};
        vecs[11] = '{1'b0, 32'h0f00_0000, 4'd12, 8'd2, 3'd2, 2'b00, 32'h0,         4'h0, -1, 16'hffff, 2'b00};
        vecs[12] = '{1'b0, 32'h0f00_0020, 4'd13, 8'd3, 3'd0, 2'b01, 32'h0,         4'h0, -1, 16'hffff, 2'b00};
        vecs[13] = '{1'b1, 32'h0f00_0ffc, 4'd14, 8'd1, 3'd2, 2'b01, 32'h0bad_f00d, 4'hf, -1, 16'hffff, 2'b11};
        vecs[14] = '{1'b0, 32'h0f00_0ffc, 4'd15, 8'd1, 3'd2, 2'b01, 32'h0,         4'h0, -1, 16'hffff, 2'b00};
        vecs[15] = '{1'b0, 32'h0f00_0000, 4'd0,  8'd0, 3'd3, 2'b01, 32'h0,         4'h0, -1, 16'hffff, 2'b00};
        vecs[16] = '{1'b1, 32'h0f00_0030, 4'd2,  8'd0, 3'd2, 2'b11, 32'h5a5a_5a5a, 4'hf, -1, 16'hffff, 2'b10};

        // Reset values while reset is held low.
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("reset arready", 32'(arready), 32'd0);
        check("reset awready", 32'(awready), 32'd0);
        check("reset rvalid", 32'(rvalid), 32'd0);
        check("reset bvalid", 32'(bvalid), 32'd0);
        check("reset wready", 32'(wready), 32'd0);
        check("reset rlast", 32'(rlast), 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset rresp", 32'(rresp), 32'd0);
        check("reset bid", 32'(bid), 32'd0);
        check("reset bresp", 32'(bresp), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // AR and AW together out of reset: read first, then the write.
        ar_addr = 32'h0000_0000; ar_id = 4'd3; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'b01;
        aw_addr = 32'h0f00_0080; aw_id = 4'd9; aw_len = 8'd0; aw_size = 3'd2; aw_burst = 2'b01;
        ar_valid = 1'b1;
        aw_valid = 1'b1;
        @(negedge clock);
        check("tie arready", 32'(arready), 32'd1);
        check("tie awready", 32'(awready), 32'd0);
        @(posedge clock);
        #1 r_ready = 1'b1;
        @(negedge clock);
        check("tie rvalid", 32'(rvalid), 32'd1);
        check("tie rresp", 32'(rresp), 32'd3);
        check("tie rdata", rdata, 32'd0);
        check("tie rid", 32'(rid), 32'd3);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("alt arready", 32'(arready), 32'd0);
        check("alt awready", 32'(awready), 32'd1);
        @(posedge clock);
        #1;
        ar_valid = 1'b0; aw_valid = 1'b0; r_ready = 1'b0;
        w_data = 32'h5555_aaaa; w_strb = 4'hf; w_last = 1'b1; w_valid = 1'b1;
        @(negedge clock);
        check("alt wready", 32'(wready), 32'd1);
        @(posedge clock);
        #1;
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1;
        @(negedge clock);
        check("alt bvalid", 32'(bvalid), 32'd1);
        check("alt bid", 32'(bid), 32'd9);
        check("alt bresp", 32'(bresp), 32'd0);
        @(posedge clock);
        #1 b_ready = 1'b0;
        mdl[30'h03c0_0020] = 32'h5555_aaaa;

        for (int i = 0; i < NumVec; i++) begin
            if (vecs[i].wr) axi_write(vecs[i]);
            else axi_read(vecs[i]);
        end

        // Reset during beat 2 of a 4-beat read; memory must survive.
        ar_addr = 32'h0f00_0000; ar_id = 4'd1; ar_len = 8'd3; ar_size = 3'd2; ar_burst = 2'b01;
        ar_valid = 1'b1;
        wait_hs(0, "ar before reset");
        ar_valid = 1'b0;
        r_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("beat2 rdata", rdata, 32'h1000_0002);
        #2 reset = 1'b0;
        #1;
        check("async rvalid", 32'(rvalid), 32'd0);
        check("async rlast", 32'(rlast), 32'd0);
        check("async rdata", rdata, 32'd0);
        check("async arready", 32'(arready), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        r_ready = 1'b0;
        @(negedge clock);
        check("post reset arready", 32'(arready), 32'd1);
        @(posedge clock);
        #1;
        axi_read('{1'b0, 32'h0f00_0000, 4'd4, 8'd3, 3'd2, 2'b01, 32'h0, 4'h0, -1, 16'hffff, 2'b00});
        axi_read('{1'b0, 32'h0f00_0080, 4'd5, 8'd0, 3'd2, 2'b01, 32'h0, 4'h0, -1, 16'hffff, 2'b00});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_axi4_slave_mem.md
Name: ysyx_axi4_slave_mem

Overview:
- AXI4 responder (slave) backed by an internal word-addressed SRAM array; it is the other end of the core's AXI4 master port.
- Instantiated in the SoC/sim top, or behind the core's io_slave_* port, as local scratchpad and test memory.
- Handles one outstanding transaction at a time: FIXED/INCR bursts, narrow writes via strobes, and read/write arbitration between the two address channels.

Parameters:
XLEN, 32, data and address width.
DEPTH, 1024, SRAM depth in XLEN-bit words (power of 2).
BASE_ADDR, 32'h0f00_0000, first decoded byte address; window is DEPTH*4 bytes.

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
io_slave_araddr/arid/arlen/arsize/arburst  in  XLEN/4/8/3/2  read address channel
io_slave_arvalid  in  1 ; io_slave_arready  out  1
io_slave_rdata/rid/rresp/rlast  out  XLEN/4/2/1  read data channel
io_slave_rvalid  out  1 ; io_slave_rready  in  1
io_slave_awaddr/awid/awlen/awsize/awburst  in  XLEN/4/8/3/2  write address channel
io_slave_awvalid  in  1 ; io_slave_awready  out  1
io_slave_wdata/wstrb/wlast  in  XLEN/4/1 ; io_slave_wvalid  in  1 ; io_slave_wready  out  1
io_slave_bid/bresp  out  4/2 ; io_slave_bvalid  out  1 ; io_slave_bready  in  1

Behaviour:
- FSM states: IDLE, RDATA, WDATA, BRESP. Reset (reset==0) forces IDLE, last_write=1, beat counter 0.
- Reset values: rvalid, bvalid, wready, rlast = 0; rdata, rid, rresp, bid, bresp = 0. arready and awready are 0 while reset is asserted.
- SRAM contents are not reset. Beats already written before a mid-burst reset stay committed.
- IDLE readies (combinational, IDLE only):
  - arready = !awvalid || last_write
  - awready = !arvalid || !last_write
  - With both valids high, exactly one ready is asserted, so the channels alternate round-robin. On a tie immediately after reset, read wins.
- AR handshake:
  - Latch addr, id, len, size, burst; set last_write=0; go to RDATA.
  - rvalid=1 in the next cycle with beat 0. rdata is registered and carries the full aligned word at addr[..:2] for narrow reads.
  - rvalid stays high across beats, one beat per cycle while rready=1. rdata/rid/rresp/rlast are held stable while rvalid && !rready.
  - rlast=1 when beat index == len. After the last-beat handshake, go to IDLE; arready can be 1 the following cycle.
- AW handshake:
  - Latch fields; set last_write=1; go to WDATA. wready=1 from the next cycle.
  - Each W handshake writes the bytes whose wstrb bit is set.
  - After beat len (count-based, not wlast-based), wready=0 next cycle and go to BRESP with bvalid=1. bvalid is held until bready, then return to IDLE.
- Address generation:
  - FIXED (2'b00): address constant.
  - INCR (2'b01): addr += 1<<size per beat, with 32-bit wrap-around.
  - WRAP (2'b10) and reserved (2'b11): unsupported.
- Response codes, per beat:
  - DECERR (2'b11) when the beat address is outside [BASE_ADDR, BASE_ADDR+DEPTH*4). Reads return 0; writes are dropped.
  - SLVERR (2'b10) when burst is unsupported or size > 2. Writes are dropped and reads return 0.
  - Otherwise OKAY (2'b00).
- bresp reports the worst response over all beats, ordered OKAY < SLVERR < DECERR.
- A write with wlast mismatching the beat count (asserted early, or missing on beat len) yields SLVERR in bresp; data beats are still written.
- bid echoes awid; rid echoes arid.
- A new AR/AW is never accepted outside IDLE.

Decomposition:
- Package ysyx_axi4_pkg:
  - Burst constants FIXED/INCR/WRAP.
  - Response constants OKAY/EXOKAY/SLVERR/DECERR.
  - State enum and a resp-max function.
- Sub-module ysyx_axi4_addr_gen: combinational next-address and in-window check (addr, size, burst -> next_addr, in_range). It is reused by future AXI4 peripherals.

Test Plan:
- Single write then read:
  - AW 0x0f00_0010 len0 size2, W 0xdead_beef strb 0xf -> bvalid with bresp 0, bid = awid.
  - AR same address -> rdata 0xdead_beef, rlast 1, rresp 0, one cycle after the AR handshake.
- INCR read burst with backpressure:
  - arlen 3 from 0x0f00_0000, rready toggled 1,0,1,1,0,1 -> 4 beats, data held stable during stalls, rlast only on beat 3.
- Narrow strobe writes:
  - Word preset 0x1122_3344, then write strb 0b0010 with wdata 0xaaaa_bbbb -> readback 0x1122_bb44.
- Simultaneous AR and AW:
  - Both valid out of reset -> read granted first. Then, with both pending again, the write is granted (alternation).
- Errors:
  - awaddr 0x8000_0000 -> bresp 2'b11.
  - arburst 2'b10 -> every beat rresp 2'b10, rdata 0.
  - wlast early on a len-3 burst -> bresp 2'b10.
- Mid-burst reset:
  - reset=0 during beat 2 of a 4-beat read -> rvalid=0 immediately (asynchronous).
  - After release, arready=1 in IDLE and a subsequent read returns the pre-reset memory contents.
